mult_pipe_fu: RTL and testbench

Parametrised, fully pipelined multiply functional unit for the issue/complete datapath. It executes MUL, MULH, MULHSU and MULHU over a configurable number of pipeline stages and accepts one operation per cycle. It uses the same execute/complete/branch-recover handshake as the single-cycle ALU, so the issue stage and CDB arbiter drive either unit identically. Multiplies leave the 1-cycle ALU path, which removes the full-width combinational multiplier from the critical path.

---
 rtl/mult_pipe_fu.sv | 198 +++++++++++++++++++
 tb/tb_mult_pipe_fu.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_fu.sv
// mult_pipe_fu: fully pipelined multiply functional unit (MUL, MULH, MULHSU, MULHU).
//
// Accepts one operation per cycle and returns its result STAGES cycles later.
// It uses the same execute/complete/branch-recover handshake as the single-cycle ALU.
// Each stage adds one C = XLEN/STAGES bit slice of opb's partial product into a
// 2*XLEN accumulator. The last stage applies the sign correction for a negative
// extended opb.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   opa, opb              operands (XLEN)
//   func                  ALU function code (5 bits); only the four multiply codes are legal
//   dest_reg_i            destination physical tag (TAG_W)
//   dest_reg_sel_i        destination select (2 bits: 0 = DEST_RD, 1 = DEST_NONE)
//   execute_en_i          issue strobe, honoured only while ready_o = 1
//   complete_en_i         CDB grant for the result held in the output slot
//   branch_recover_i      bit 0 flushes every in-flight op; bit 1 is ignored
//   ready_o               the unit accepts an op this cycle
//   done_o                the output slot holds a finished result
//   result_o, dest_reg_o, dest_reg_sel_o   contents of the output slot
//   regfile_wr_en_o       complete_en_i & done_o & (dest_reg_sel_o == DEST_RD)
//
// Optional feature, enabled by defining MULT_PIPE_FU_STALL_CNT_EN:
//   stall_cnt_o (32)      cycles spent stalled
//   op_cnt_o    (32)      accepted operations
module mult_pipe_fu #(
  parameter int XLEN        = 32,
  parameter int STAGES      = 4,
  parameter int PREG_NUMBER = 64,
  localparam int TAG_W      = $clog2(PREG_NUMBER)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  opa,
  input  logic [XLEN-1:0]  opb,
  input  logic [4:0]       func,
  input  logic [TAG_W-1:0] dest_reg_i,
  input  logic [1:0]       dest_reg_sel_i,
  input  logic             execute_en_i,
  input  logic             complete_en_i,
  input  logic [1:0]       branch_recover_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] dest_reg_o,
  output logic [1:0]       dest_reg_sel_o,
  output logic             regfile_wr_en_o
`ifdef MULT_PIPE_FU_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      op_cnt_o
`endif
);

  localparam int C  = XLEN / STAGES;
  localparam int AW = 2 * XLEN;

  localparam logic [4:0] ALU_MUL    = 5'h0a;
  localparam logic [4:0] ALU_MULH   = 5'h0b;
  localparam logic [4:0] ALU_MULHSU = 5'h0c;
  localparam logic [4:0] ALU_MULHU  = 5'h0d;

  localparam logic [1:0] DEST_RD   = 2'd0;
  localparam logic [1:0] DEST_NONE = 2'd1;

  // Extend an operand to XLEN+1 bits, either sign- or zero-extended.
  function automatic logic signed [XLEN:0] ext_op(logic [XLEN-1:0] op, logic sgn);
    return $signed({sgn & op[XLEN-1], op});
  endfunction

  // Signed extended operand times an unsigned slice of opb, shifted into place,
  // modulo 2^(2*XLEN).
  function automatic logic signed [AW-1:0] part_prod(logic signed [XLEN:0] a,
                                                     logic [C-1:0] c,
                                                     int unsigned sh);
    logic signed [AW-1:0] a_w;
    logic signed [AW-1:0] c_w;
    a_w = AW'(a);
    c_w = AW'({1'b0, c});
    return (a_w * c_w) <<< sh;
  endfunction

  // Pick the low or high word of the accumulator. Illegal codes give a marker value.
  function automatic logic [XLEN-1:0] sel_result(logic [4:0] f, logic signed [AW-1:0] acc);
    case (f)
      ALU_MUL:                         return acc[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: return acc[AW-1:XLEN];
      default:                         return XLEN'(32'hfacebeec);
    endcase
  endfunction

  logic flush;
  logic stall;

  // Stage registers; index STAGES-1 is the output slot.
  logic                    vld_p  [STAGES];
  logic [TAG_W-1:0]        tag_p  [STAGES];
  logic [1:0]              sel_p  [STAGES];
  logic [4:0]              func_p [STAGES];
  logic signed [XLEN:0]    opa_p  [STAGES];
  logic signed [XLEN:0]    opb_p  [STAGES];
  logic signed [AW-1:0]    acc_p  [STAGES];

  // Values entering each stage and the stage's next accumulator.
  logic                    in_vld  [STAGES];
  logic [TAG_W-1:0]        in_tag  [STAGES];
  logic [1:0]              in_sel  [STAGES];
  logic [4:0]              in_func [STAGES];
  logic signed [XLEN:0]    in_opa  [STAGES];
  logic signed [XLEN:0]    in_opb  [STAGES];
  logic signed [AW-1:0]    in_acc  [STAGES];
  logic signed [AW-1:0]    nxt_acc [STAGES];

  assign flush   = branch_recover_i[0];
  assign done_o  = vld_p[STAGES-1];
  // A full output slot that is not granted the CDB freezes the whole pipe.
  assign stall   = done_o & ~complete_en_i;
  assign ready_o = ~stall | flush;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic signed [AW-1:0] sum;

      if (k == 0) begin : g_issue
        assign in_vld[k]  = execute_en_i;
        assign in_tag[k]  = dest_reg_i;
        assign in_sel[k]  = dest_reg_sel_i;
        assign in_func[k] = func;
        assign in_opa[k]  = ext_op(opa, func != ALU_MULHU);
        assign in_opb[k]  = ext_op(opb, (func == ALU_MUL) || (func == ALU_MULH));
        assign in_acc[k]  = '0;
      end else begin : g_chain
        assign in_vld[k]  = vld_p[k-1];
        assign in_tag[k]  = tag_p[k-1];
        assign in_sel[k]  = sel_p[k-1];
        assign in_func[k] = func_p[k-1];
        assign in_opa[k]  = opa_p[k-1];
        assign in_opb[k]  = opb_p[k-1];
        assign in_acc[k]  = acc_p[k-1];
      end

      assign sum = in_acc[k] + part_prod(in_opa[k], in_opb[k][k*C +: C], k*C);

      if (k == STAGES - 1) begin : g_last
        // opb_ext bit XLEN carries weight -2^XLEN, which the unsigned slices miss.
        assign nxt_acc[k] = in_opb[k][XLEN] ? sum - (AW'(in_opa[k]) <<< XLEN) : sum;
      end else begin : g_mid
        assign nxt_acc[k] = sum;
      end
    end
  endgenerate

  // ---- stage boundary: valid bits (reset and flush clear, stall holds) ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
    end else if (!stall) begin
      for (int i = 0; i < STAGES; i++) vld_p[i] <= in_vld[i];
    end
  end

  // ---- stage boundary: payload registers, qualified by the valid bits ----
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int i = 0; i < STAGES; i++) begin
        tag_p[i]  <= in_tag[i];
        sel_p[i]  <= in_sel[i];
        func_p[i] <= in_func[i];
        opa_p[i]  <= in_opa[i];
        opb_p[i]  <= in_opb[i];
        acc_p[i]  <= nxt_acc[i];
      end
    end
  end

  // The payload is never reset, so an empty slot presents the idle values.
  assign result_o        = done_o ? sel_result(func_p[STAGES-1], acc_p[STAGES-1]) : '0;
  assign dest_reg_o      = done_o ? tag_p[STAGES-1] : '0;
  assign dest_reg_sel_o  = done_o ? sel_p[STAGES-1] : DEST_NONE;
  assign regfile_wr_en_o = complete_en_i & done_o & (dest_reg_sel_o == DEST_RD);

  logic unused_bits;
  assign unused_bits = ^{branch_recover_i[1], opa_p[STAGES-1], opb_p[STAGES-1]};

`ifdef MULT_PIPE_FU_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_o <= '0;
      op_cnt_o    <= '0;
    end else begin
      if (stall) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (execute_en_i && !stall && !flush) op_cnt_o <= op_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_pipe_fu.sv
// Testbench for mult_pipe_fu (XLEN=32, STAGES=4): scoreboard of expected results
// pushed on acceptance and popped on completion, plus directed timing checks.
module tb_mult_pipe_fu;

  localparam logic [4:0] F_MUL    = 5'h0a;
  localparam logic [4:0] F_MULH   = 5'h0b;
  localparam logic [4:0] F_MULHSU = 5'h0c;
  localparam logic [4:0] F_MULHU  = 5'h0d;
  localparam logic [4:0] F_BAD    = 5'h00;
  localparam logic [1:0] SEL_RD   = 2'd0;
  localparam logic [1:0] SEL_NONE = 2'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] opa, opb;
  logic [4:0]  func;
  logic [5:0]  dest_reg_i;
  logic [1:0]  dest_reg_sel_i;
  logic        execute_en_i, complete_en_i;
  logic [1:0]  branch_recover_i;
  logic        ready_o, done_o, regfile_wr_en_o;
  logic [31:0] result_o;
  logic [5:0]  dest_reg_o;
  logic [1:0]  dest_reg_sel_o;
`ifdef MULT_PIPE_FU_STALL_CNT_EN
  logic [31:0] stall_cnt_o, op_cnt_o;
`endif

  mult_pipe_fu dut (
    .clk(clk), .reset(reset), .opa(opa), .opb(opb), .func(func),
    .dest_reg_i(dest_reg_i), .dest_reg_sel_i(dest_reg_sel_i),
    .execute_en_i(execute_en_i), .complete_en_i(complete_en_i),
    .branch_recover_i(branch_recover_i), .ready_o(ready_o), .done_o(done_o),
    .result_o(result_o), .dest_reg_o(dest_reg_o), .dest_reg_sel_o(dest_reg_sel_o),
    .regfile_wr_en_o(regfile_wr_en_o)
`ifdef MULT_PIPE_FU_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .op_cnt_o(op_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    logic [1:0]  sel;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int n_assert  = 0;
  int n_fail    = 0;
  int n_retired = 0;
  int tb_ops    = 0;
  int tb_stalls = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference product via plain 64-bit arithmetic.
  function automatic logic [31:0] model(logic [4:0] f, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sbv, ub_s;
    logic [63:0] ua, ub, p;
    sa   = {{32{a[31]}}, a};
    sbv  = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    ub_s = ub;
    case (f)
      F_MUL:    begin p = ua * ub;   return p[31:0];  end
      F_MULH:   begin p = sa * sbv;  return p[63:32]; end
      F_MULHSU: begin p = sa * ub_s; return p[63:32]; end
      F_MULHU:  begin p = ua * ub;   return p[63:32]; end
      default:  return 32'hfacebeec;
    endcase
  endfunction

  task automatic set_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tg, input logic [1:0] sl, input logic [31:0] ex);
    func = f; opa = a; opb = b; dest_reg_i = tg; dest_reg_sel_i = sl;
    cur.res = ex; cur.tag = tg; cur.sel = sl;
  endtask

  // Present one op for one cycle; entered and left just after a rising edge.
  task automatic drive(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tg, input logic [1:0] sl, input logic [31:0] ex);
    set_op(f, a, b, tg, sl, ex);
    execute_en_i = 1'b1;
    @(posedge clk); #1;
    execute_en_i = 1'b0;
  endtask

  task automatic drive_rand(input logic [5:0] tg);
    logic [4:0]  f;
    logic [31:0] a, b;
    f = 5'h0a + 5'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
    drive(f, a, b, tg, SEL_RD, model(f, a, b));
  endtask

  task automatic wait_done(input string tg);
    int n;
    n = 0;
    @(negedge clk);
    while (!done_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tg, "_done"}, done_o, 1);
  endtask

  // Scoreboard: push on acceptance, pop and compare on completion.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      sb.delete();
      tb_ops    = 0;
      tb_stalls = 0;
    end else begin
      if (done_o && !complete_en_i) tb_stalls++;
      if (branch_recover_i[0]) begin
        sb.delete();
      end else begin
        if (done_o && complete_en_i) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_result", result_o, 64'hdead);
          end else begin
            e = sb.pop_front();
            check_eq("sb_result", result_o, e.res);
            check_eq("sb_tag", dest_reg_o, e.tag);
            check_eq("sb_sel", dest_reg_sel_o, e.sel);
            check_eq("sb_wr_en", regfile_wr_en_o, e.sel == SEL_RD);
            n_retired++;
          end
        end
        if (execute_en_i && ready_o) begin
          sb.push_back(cur);
          tb_ops++;
        end
      end
    end
  end

  initial begin
    int lat, ready_low, done_cnt, run, max_run, seen;
    logic [31:0] held;
    logic [5:0]  held_tag;

    reset = 1'b1; opa = '0; opb = '0; func = F_MUL; dest_reg_i = '0;
    dest_reg_sel_i = SEL_NONE; execute_en_i = 1'b0; complete_en_i = 1'b0;
    branch_recover_i = 2'b00;
    cur.res = '0; cur.tag = '0; cur.sel = SEL_NONE;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_ready", ready_o, 1);
    check_eq("rst_result", result_o, 0);
    check_eq("rst_dest", dest_reg_o, 0);
    check_eq("rst_sel", dest_reg_sel_o, SEL_NONE);
    check_eq("rst_wr_en", regfile_wr_en_o, 0);
    @(posedge clk); #1;

    // MUL 7 * -3, latency
    complete_en_i = 1'b1;
    drive(F_MUL, 32'd7, 32'hfffffffd, 6'd5, SEL_RD, 32'hffffffeb);
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (done_o) break;
      @(posedge clk); #1;
      lat++;
    end
    check_eq("mul_latency", lat, 4);
    check_eq("mul_result", result_o, 32'hffffffeb);
    check_eq("mul_wr_en", regfile_wr_en_o, 1);
    @(posedge clk); #1;

    // High words and an illegal code
    drive(F_MULH,   32'h80000000, 32'hffffffff, 6'd10, SEL_RD,   32'h00000000);
    drive(F_MULHSU, 32'h80000000, 32'hffffffff, 6'd11, SEL_RD,   32'h80000000);
    drive(F_MULHU,  32'h80000000, 32'hffffffff, 6'd12, SEL_NONE, 32'h7fffffff);
    drive(F_BAD,    32'h12345678, 32'h9abcdef0, 6'd13, SEL_RD,   32'hfacebeec);
    repeat (8) @(posedge clk);
    #1;
    check_eq("hi_retired", n_retired, 5);

    // Streaming: 8 back-to-back ops
    ready_low = 0; done_cnt = 0; run = 0; max_run = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        set_op(5'h0a + 5'(i % 4), $urandom, $urandom, 6'(20 + i), SEL_RD, 32'd0);
        cur.res = model(func, opa, opb);
        execute_en_i = 1'b1;
      end else begin
        execute_en_i = 1'b0;
      end
      @(negedge clk);
      if (!ready_o) ready_low++;
      if (done_o) begin
        done_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      @(posedge clk); #1;
    end
    execute_en_i = 1'b0;
    check_eq("stream_ready_low", ready_low, 0);
    check_eq("stream_done_cnt", done_cnt, 8);
    check_eq("stream_consecutive", max_run, 8);
    check_eq("stream_retired", n_retired, 13);

    // Backpressure
    complete_en_i = 1'b0;
    drive_rand(6'd40);
    drive_rand(6'd41);
    drive_rand(6'd42);
    wait_done("bp");
    held = result_o;
    held_tag = dest_reg_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      set_op(F_MUL, 32'd3, 32'd3, 6'd63, SEL_RD, 32'd9);
      execute_en_i = 1'b1;
      @(negedge clk);
      check_eq("bp_hold_result", result_o, held);
      check_eq("bp_hold_tag", dest_reg_o, held_tag);
      check_eq("bp_ready", ready_o, 0);
    end
    @(posedge clk); #1;
    execute_en_i = 1'b0;
    complete_en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_drain_done", done_o, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("bp_empty", done_o, 0);
    @(posedge clk); #1;
    check_eq("bp_retired", n_retired, 16);
`ifdef MULT_PIPE_FU_STALL_CNT_EN
    check_eq("cnt_ops", op_cnt_o, tb_ops);
    check_eq("cnt_stalls", stall_cnt_o, tb_stalls);
`endif

    // Flush with 3 ops in flight plus a same-cycle issue
    drive_rand(6'd50);
    drive_rand(6'd51);
    drive_rand(6'd52);
    set_op(F_MUL, 32'd2, 32'd2, 6'd53, SEL_RD, 32'd4);
    execute_en_i = 1'b1;
    branch_recover_i = 2'b01;
    @(posedge clk); #1;
    execute_en_i = 1'b0;
    branch_recover_i = 2'b00;
    @(negedge clk);
    check_eq("flush_done", done_o, 0);
    check_eq("flush_ready", ready_o, 1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_o) seen++;
    end
    check_eq("flush_no_result", seen, 0);
    check_eq("flush_retired", n_retired, 16);
    @(posedge clk); #1;

    // Reset while the output slot is stalled
    complete_en_i = 1'b0;
    drive(F_MULHU, 32'hffffffff, 32'hffffffff, 6'd33, SEL_RD, 32'hfffffffe);
    wait_done("rst_stall");
    check_eq("rst_stall_ready", ready_o, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    complete_en_i = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst2_done", done_o, 0);
    check_eq("rst2_ready", ready_o, 1);
    check_eq("rst2_result", result_o, 0);
    check_eq("rst2_dest", dest_reg_o, 0);
    check_eq("rst2_sel", dest_reg_sel_o, SEL_NONE);
    check_eq("rst2_wr_en", regfile_wr_en_o, 0);
`ifdef MULT_PIPE_FU_STALL_CNT_EN
    check_eq("rst2_stall_cnt", stall_cnt_o, 0);
    check_eq("rst2_op_cnt", op_cnt_o, 0);
`endif
    @(posedge clk); #1;

    // Recovery after reset
    drive(F_MULHU, 32'h00010000, 32'h00010000, 6'd7, SEL_RD, 32'h00000001);
    repeat (6) @(posedge clk);
    #1;
    check_eq("recover_retired", n_retired, 17);
    check_eq("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
